// File: rtl/msu_pkg.sv
// Shared types for the MSU-1 audio FIFO refill controller.
package msu_pkg;

    localparam int MSU_BURST_LEN_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH_HI,
        ST_FLUSH_LO,
        ST_WAIT,
        ST_REQ,
        ST_XFER,
        ST_END
    } msu_state_e;

endpackage

// File: rtl/msu_flush_timer.sv
// Down-counter timing one flush phase; reload on i_load, o_done when it reaches zero.
module msu_flush_timer #(
    parameter int FLUSH_CYC = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_done
);

    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(FLUSH_CYC - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/msu_audio_fill_ctrl.sv
// MSU-1 audio FIFO refill sequencer: watermark-driven burst reads, flush on track start,
// loop-point wrap, track end and play/pause gating.
module msu_audio_fill_ctrl
    import msu_pkg::*;
#(
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 10,
    parameter int BURST     = 64,
    parameter int LOW_WATER = 512,
    parameter int FLUSH_CYC = 8
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       play,
    // "repeat" is a reserved word, hence the suffix
    input  logic                       repeat_en,
    input  logic                       track_start,
    input  logic [ADDR_W-1:0]          start_addr,
    input  logic [ADDR_W-1:0]          loop_addr,
    input  logic [ADDR_W-1:0]          end_addr,
    input  logic [DEPTH-1:0]           fifo_wrusedw,
    input  logic                       fifo_wrfull,
    output logic                       fifo_clr,
    output logic                       fifo_wrreq,
    output logic [DATA_W-1:0]          fifo_data,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [MSU_BURST_LEN_W-1:0] mem_len,
    input  logic                       mem_ack,
    input  logic                       mem_valid,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       playing,
    output logic                       track_end,
    output logic                       overflow
);

    localparam int LEN_W = MSU_BURST_LEN_W;
    localparam logic [LEN_W-1:0] BURST_C = LEN_W'(BURST);
    localparam logic [DEPTH:0]   LW_C    = (DEPTH + 1)'(LOW_WATER);

    // Words left to end_addr inclusive, saturated at one burst; span = end - cur.
    function automatic logic [LEN_W-1:0] f_burst_len(input logic [ADDR_W-1:0] span);
        if (span >= ADDR_W'(BURST - 1)) begin
            return BURST_C;
        end
        return LEN_W'(span) + LEN_W'(1);
    endfunction

    msu_state_e        r_state;
    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W-1:0] r_loop;
    logic [ADDR_W-1:0] r_end;
    logic [ADDR_W-1:0] r_cur;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_restart_pend;

    logic              w_tmr_done;
    logic              w_tmr_load;
    logic              w_restart_now;
    logic              w_pend;
    logic              w_xfer_last;
    logic              w_flush_go;
    logic              w_fill_need;
    logic [ADDR_W-1:0] w_span;

    // A restart arriving while a burst is in flight waits until the burst drains.
    assign w_restart_now = track_start && (r_state != ST_REQ) && (r_state != ST_XFER);
    assign w_pend        = r_restart_pend | track_start;
    assign w_xfer_last   = (r_state == ST_XFER) && mem_valid && (r_remaining == LEN_W'(1));
    assign w_flush_go    = w_restart_now | (w_xfer_last & w_pend);
    assign w_tmr_load    = w_flush_go | ((r_state == ST_FLUSH_HI) & w_tmr_done);
    assign w_fill_need   = play && ({1'b0, fifo_wrusedw} < LW_C);
    assign w_span        = r_end - r_cur;

    msu_flush_timer #(
        .FLUSH_CYC (FLUSH_CYC)
    ) u_flush_timer (
        .i_clk  (clk_sys),
        .i_rst  (reset),
        .i_load (w_tmr_load),
        .o_done (w_tmr_done)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_start        <= '0;
            r_loop         <= '0;
            r_end          <= '0;
            r_cur          <= '0;
            r_remaining    <= '0;
            r_restart_pend <= 1'b0;
            fifo_clr       <= 1'b0;
            fifo_wrreq     <= 1'b0;
            fifo_data      <= '0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            mem_len        <= '0;
            playing        <= 1'b0;
            track_end      <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            fifo_wrreq <= 1'b0;

            if (track_start) begin
                r_start   <= start_addr;
                r_loop    <= loop_addr;
                r_end     <= end_addr;
                overflow  <= 1'b0;
                track_end <= 1'b0;
            end

            if (w_flush_go) begin
                r_state        <= ST_FLUSH_HI;
                r_cur          <= w_restart_now ? start_addr : r_start;
                r_restart_pend <= 1'b0;
                fifo_clr       <= 1'b1;
                mem_req        <= 1'b0;
                playing        <= 1'b1;
            end else begin
                case (r_state)
                    ST_FLUSH_HI: begin
                        if (w_tmr_done) begin
                            fifo_clr <= 1'b0;
                            r_state  <= ST_FLUSH_LO;
                        end
                    end
                    ST_FLUSH_LO: begin
                        if (w_tmr_done) begin
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (w_fill_need) begin
                            mem_req  <= 1'b1;
                            mem_addr <= r_cur;
                            mem_len  <= f_burst_len(w_span);
                            r_state  <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (track_start) begin
                            r_restart_pend <= 1'b1;
                        end
                        if (mem_ack) begin
                            mem_req     <= 1'b0;
                            r_remaining <= mem_len;
                            r_state     <= ST_XFER;
                        end
                    end
                    ST_XFER: begin
                        if (track_start) begin
                            r_restart_pend <= 1'b1;
                        end
                        if (mem_valid) begin
                            r_cur       <= r_cur + ADDR_W'(1);
                            r_remaining <= r_remaining - LEN_W'(1);
                            // Words of a burst being drained for a restart are discarded.
                            if (!w_pend) begin
                                if (fifo_wrfull) begin
                                    overflow <= 1'b1;
                                end else begin
                                    fifo_wrreq <= 1'b1;
                                    fifo_data  <= mem_data;
                                end
                            end
                            if (w_xfer_last) begin
                                if (r_cur == r_end) begin
                                    if (repeat_en) begin
                                        r_cur   <= r_loop;
                                        r_state <= ST_WAIT;
                                    end else begin
                                        playing   <= 1'b0;
                                        track_end <= 1'b1;
                                        r_state   <= ST_END;
                                    end
                                end else begin
                                    r_state <= ST_WAIT;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msu_audio_fill_ctrl.sv
// Directed bench for msu_audio_fill_ctrl: flush timing, bursts, wrap/end, restart, overflow, watermark.
module tb_msu_audio_fill_ctrl;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          play;
    logic          repeat_en;
    logic          track_start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] loop_addr;
    logic [AW-1:0] end_addr;
    logic [9:0]    fifo_wrusedw;
    logic          fifo_wrfull;
    logic          fifo_clr;
    logic          fifo_wrreq;
    logic [DW-1:0] fifo_data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [8:0]    mem_len;
    logic          mem_ack;
    logic          mem_valid;
    logic [DW-1:0] mem_data;
    logic          playing;
    logic          track_end;
    logic          overflow;

    int n_chk  = 0;
    int n_fail = 0;

    msu_audio_fill_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(10), .BURST(64), .LOW_WATER(512), .FLUSH_CYC(8)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .play(play), .repeat_en(repeat_en),
        .track_start(track_start), .start_addr(start_addr), .loop_addr(loop_addr),
        .end_addr(end_addr), .fifo_wrusedw(fifo_wrusedw), .fifo_wrfull(fifo_wrfull),
        .fifo_clr(fifo_clr), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len), .mem_ack(mem_ack),
        .mem_valid(mem_valid), .mem_data(mem_data), .playing(playing),
        .track_end(track_end), .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_start();
        track_start = 1'b1;
        tick();
        track_start = 1'b0;
    endtask

    task automatic wait_req(input int max_cyc);
        int n = 0;
        while (mem_req !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("req_seen", {63'd0, mem_req}, 64'd1);
    endtask

    task automatic ack();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("req_drop_after_ack", {63'd0, mem_req}, 64'd0);
    endtask

    // Counts fifo_clr-high samples, then samples until mem_req rises.
    task automatic measure_flush(output int hi, output int gap);
        hi  = 0;
        gap = 0;
        while (fifo_clr === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
        while (mem_req !== 1'b1 && gap < 100) begin
            gap++;
            tick();
        end
    endtask

    task automatic count_req(input int cyc, output int c);
        c = 0;
        for (int i = 0; i < cyc; i++) begin
            tick();
            if (mem_req === 1'b1) c++;
        end
    endtask

    // Streams n words; ts_at inserts a restart gap before word ts_at, full_at marks wrfull,
    // play_off_at drops play. Each word must appear on fifo_wrreq exactly one cycle later.
    task automatic do_burst(input logic [AW-1:0] base, input int n, input bit pend0,
                            input int ts_at, input int full_at, input int play_off_at,
                            output int wr, output int derr, output int terr);
        logic [DW-1:0] d;
        bit            pend;
        bit            exp_wr;
        wr   = 0;
        derr = 0;
        terr = 0;
        pend = pend0;
        for (int k = 0; k < n; k++) begin
            if (k == ts_at) begin
                mem_valid = 1'b0;
                pulse_start();
                pend = 1'b1;
                if (fifo_wrreq !== 1'b0) terr++;
            end
            if (k == play_off_at) play = 1'b0;
            d           = {16'hDA7A, 16'(base + AW'(k))};
            mem_valid   = 1'b1;
            mem_data    = d;
            fifo_wrfull = (k == full_at);
            tick();
            exp_wr = !pend && (k != full_at);
            if (fifo_wrreq === 1'b1) wr++;
            if (fifo_wrreq !== exp_wr) terr++;
            if (fifo_wrreq === 1'b1 && fifo_data !== d) derr++;
        end
        mem_valid   = 1'b0;
        fifo_wrfull = 1'b0;
    endtask

    int hi, gap, wr, derr, terr, c;

    initial begin
        reset = 1'b1; play = 1'b0; repeat_en = 1'b0; track_start = 1'b0;
        start_addr = '0; loop_addr = '0; end_addr = '0;
        fifo_wrusedw = '0; fifo_wrfull = 1'b0;
        mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
        for (int i = 0; i < 3; i++) tick();

        // Reset state
        chk("rst_fifo_clr",   {63'd0, fifo_clr},   64'd0);
        chk("rst_fifo_wrreq", {63'd0, fifo_wrreq}, 64'd0);
        chk("rst_fifo_data",  {32'd0, fifo_data},  64'd0);
        chk("rst_mem_req",    {63'd0, mem_req},    64'd0);
        chk("rst_mem_addr",   {34'd0, mem_addr},   64'd0);
        chk("rst_mem_len",    {55'd0, mem_len},    64'd0);
        chk("rst_playing",    {63'd0, playing},    64'd0);
        chk("rst_track_end",  {63'd0, track_end},  64'd0);
        chk("rst_overflow",   {63'd0, overflow},   64'd0);
        reset = 1'b0;
        tick();

        // Track start: clr high 8 cycles, FLUSH_LO 8 cycles plus the registered WAIT decision
        start_addr = 30'h100; loop_addr = 30'h100; end_addr = 30'h1FF; play = 1'b1;
        pulse_start();
        measure_flush(hi, gap);
        chk("t1_clr_hi_cycles", 64'(hi), 64'd8);
        chk("t1_clr_lo_to_req", 64'(gap), 64'd9);
        chk("t1_playing", {63'd0, playing}, 64'd1);
        chk("t1_addr", {34'd0, mem_addr}, 64'h100);
        chk("t1_len",  {55'd0, mem_len},  64'd64);

        // Full 64-word burst
        ack();
        do_burst(30'h100, 64, 1'b0, -1, -1, -1, wr, derr, terr);
        chk("t2_wr_count", 64'(wr), 64'd64);
        chk("t2_data_err", 64'(derr), 64'd0);
        chk("t2_wr_timing_err", 64'(terr), 64'd0);
        wait_req(5);
        chk("t2_next_addr", {34'd0, mem_addr}, 64'h140);
        chk("t2_next_len",  {55'd0, mem_len},  64'd64);

        // Restart after 10 of 64 words; remaining 54 discarded, new track is a short looping one
        start_addr = 30'h100; loop_addr = 30'h104; end_addr = 30'h10F; repeat_en = 1'b1;
        ack();
        do_burst(30'h140, 64, 1'b0, 10, -1, -1, wr, derr, terr);
        chk("t4_wr_count", 64'(wr), 64'd10);
        chk("t4_data_err", 64'(derr), 64'd0);
        chk("t4_wr_timing_err", 64'(terr), 64'd0);
        measure_flush(hi, gap);
        chk("t4_clr_hi_cycles", 64'(hi), 64'd8);
        chk("t4_clr_lo_to_req", 64'(gap), 64'd9);
        chk("t4_new_addr", {34'd0, mem_addr}, 64'h100);
        chk("t3_len16", {55'd0, mem_len}, 64'd16);

        // Loop-point wrap, then end of a non-repeating pass
        ack();
        do_burst(30'h100, 16, 1'b0, -1, -1, -1, wr, derr, terr);
        chk("t3_wr16", 64'(wr), 64'd16);
        wait_req(5);
        chk("t3_wrap_addr", {34'd0, mem_addr}, 64'h104);
        chk("t3_wrap_len",  {55'd0, mem_len},  64'd12);
        repeat_en = 1'b0;
        ack();
        do_burst(30'h104, 12, 1'b0, -1, -1, -1, wr, derr, terr);
        chk("t3_wr12", 64'(wr), 64'd12);
        chk("t3_track_end", {63'd0, track_end}, 64'd1);
        chk("t3_playing_off", {63'd0, playing}, 64'd0);
        count_req(20, c);
        chk("t3_no_req_after_end", 64'(c), 64'd0);

        // Overflow: word 5 arrives with FIFO full
        start_addr = 30'h300; loop_addr = 30'h300; end_addr = 30'h3FF;
        pulse_start();
        chk("t5_track_end_clr", {63'd0, track_end}, 64'd0);
        chk("t5_playing", {63'd0, playing}, 64'd1);
        wait_req(40);
        chk("t5_addr", {34'd0, mem_addr}, 64'h300);
        ack();
        fifo_wrusedw = 10'd512;
        do_burst(30'h300, 64, 1'b0, -1, 5, -1, wr, derr, terr);
        chk("t5_wr_count", 64'(wr), 64'd63);
        chk("t5_wr_timing_err", 64'(terr), 64'd0);
        chk("t5_data_err", 64'(derr), 64'd0);
        chk("t5_overflow", {63'd0, overflow}, 64'd1);

        // Watermark: 512 blocks, 511 requests on the next cycle
        count_req(20, c);
        chk("t6_no_req_at_512", 64'(c), 64'd0);
        fifo_wrusedw = 10'd511;
        tick();
        chk("t6_req_at_511", {63'd0, mem_req}, 64'd1);
        chk("t6_addr", {34'd0, mem_addr}, 64'h340);

        // Pause mid-burst: burst completes, then no further requests
        ack();
        do_burst(30'h340, 64, 1'b0, -1, -1, 20, wr, derr, terr);
        chk("t6_pause_wr_count", 64'(wr), 64'd64);
        count_req(20, c);
        chk("t6_no_req_paused", 64'(c), 64'd0);
        chk("t5_overflow_held", {63'd0, overflow}, 64'd1);

        // Restart during REQ: handshake completes, whole burst discarded, flags cleared
        play = 1'b1;
        wait_req(5);
        chk("t7_addr", {34'd0, mem_addr}, 64'h380);
        start_addr = 30'h500; loop_addr = 30'h500; end_addr = 30'h5FF;
        pulse_start();
        chk("t7_overflow_clr", {63'd0, overflow}, 64'd0);
        chk("t7_req_held", {63'd0, mem_req}, 64'd1);
        chk("t7_addr_stable", {34'd0, mem_addr}, 64'h380);
        ack();
        do_burst(30'h380, 64, 1'b1, -1, -1, -1, wr, derr, terr);
        chk("t7_wr_count", 64'(wr), 64'd0);
        measure_flush(hi, gap);
        chk("t7_clr_hi_cycles", 64'(hi), 64'd8);
        chk("t7_new_addr", {34'd0, mem_addr}, 64'h500);

        // Reset mid-burst: late words are not written
        ack();
        do_burst(30'h500, 3, 1'b0, -1, -1, -1, wr, derr, terr);
        chk("t8_wr_before_rst", 64'(wr), 64'd3);
        reset = 1'b1;
        mem_valid = 1'b1;
        tick();
        reset = 1'b0;
        wr = 0;
        for (int k = 0; k < 5; k++) begin
            mem_data = 32'hBAD0_0000 + 32'(k);
            tick();
            if (fifo_wrreq === 1'b1) wr++;
        end
        mem_valid = 1'b0;
        chk("t8_wr_after_rst", 64'(wr), 64'd0);
        chk("t8_playing", {63'd0, playing}, 64'd0);
        chk("t8_mem_req", {63'd0, mem_req}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
